// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared widths and per-entry layout of the reorder buffer.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif
`ifndef ARCH_REG_INDEX_SIZE
`define ARCH_REG_INDEX_SIZE 5
`endif

package reorder_buffer_pkg;
    localparam int ROB_ID_W = `ROB_ENTRY_WIDTH;
    localparam int REG_W    = `ARCH_REG_INDEX_SIZE;

    typedef struct packed {
        logic                   valid;
        logic                   ready;
        logic                   is_store;
        logic [REG_W-1:0]       rd;
        logic [`WORD_SIZE-1:0]  data;
    } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: allocation, lookup, writeback and commit signals of the reorder buffer.
interface reorder_buffer_if #(parameter int WORD_SIZE = `WORD_SIZE);
    import reorder_buffer_pkg::*;
    logic                 require_rob_entry;
    logic                 is_store;
    logic [REG_W-1:0]     rd;
    logic [ROB_ID_W-1:0]  assigned_rob_id;
    logic                 full;
    logic [ROB_ID_W-1:0]  rs1_rob_id;
    logic [ROB_ID_W-1:0]  rs2_rob_id;
    logic [WORD_SIZE-1:0] rob_s1_data;
    logic [WORD_SIZE-1:0] rob_s2_data;
    logic                 rob_s1_valid;
    logic                 rob_s2_valid;
    logic                 alu_wb_bypass_enable;
    logic                 mem_wb_bypass_enable;
    logic                 mul_wb_bypass_enable;
    logic [ROB_ID_W-1:0]  alu_wb_rob_id;
    logic [ROB_ID_W-1:0]  mem_wb_rob_id;
    logic [ROB_ID_W-1:0]  mul_wb_rob_id;
    logic [WORD_SIZE-1:0] alu_wb_data;
    logic [WORD_SIZE-1:0] mem_wb_data;
    logic [WORD_SIZE-1:0] mul_wb_data;
    logic                 jump_taken;
    logic                 commit;
    logic [REG_W-1:0]     commit_rd;
    logic [ROB_ID_W-1:0]  commit_rob_id;
    logic [WORD_SIZE-1:0] commit_data;
    logic                 commit_is_store;

    modport master (
        output require_rob_entry, is_store, rd, rs1_rob_id, rs2_rob_id,
               alu_wb_bypass_enable, mem_wb_bypass_enable, mul_wb_bypass_enable,
               alu_wb_rob_id, mem_wb_rob_id, mul_wb_rob_id,
               alu_wb_data, mem_wb_data, mul_wb_data, jump_taken,
        input  assigned_rob_id, full, rob_s1_data, rob_s2_data, rob_s1_valid, rob_s2_valid,
               commit, commit_rd, commit_rob_id, commit_data, commit_is_store
    );

    modport slave (
        input  require_rob_entry, is_store, rd, rs1_rob_id, rs2_rob_id,
               alu_wb_bypass_enable, mem_wb_bypass_enable, mul_wb_bypass_enable,
               alu_wb_rob_id, mem_wb_rob_id, mul_wb_rob_id,
               alu_wb_data, mem_wb_data, mul_wb_data, jump_taken,
        output assigned_rob_id, full, rob_s1_data, rob_s2_data, rob_s1_valid, rob_s2_valid,
               commit, commit_rd, commit_rob_id, commit_data, commit_is_store
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer with three writeback ports and flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int WORD_SIZE   = `WORD_SIZE,
    parameter int NUM_ENTRIES = 2**`ROB_ENTRY_WIDTH
) (
    input logic              clk,
    input logic              rst_n,
    reorder_buffer_if.slave  rob
);
    localparam int                  CNT_W    = ROB_ID_W + 1;
    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(NUM_ENTRIES);
    localparam logic [ROB_ID_W-1:0] LAST     = ROB_ID_W'(NUM_ENTRIES - 1);

    rob_entry_t          ent_q [NUM_ENTRIES];
    rob_entry_t          ent_d [NUM_ENTRIES];
    logic [ROB_ID_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                full, alloc, commit;

    function automatic logic [ROB_ID_W-1:0] nxt(input logic [ROB_ID_W-1:0] p);
        return p == LAST ? '0 : p + ROB_ID_W'(1);
    endfunction

    assign full   = cnt_q == FULL_CNT;
    assign alloc  = rob.require_rob_entry & ~full;
    assign commit = ent_q[head_q].valid & ent_q[head_q].ready;

    assign rob.full            = full;
    assign rob.assigned_rob_id = tail_q;
    assign rob.rob_s1_data     = WORD_SIZE'(ent_q[rob.rs1_rob_id].data);
    assign rob.rob_s2_data     = WORD_SIZE'(ent_q[rob.rs2_rob_id].data);
    assign rob.rob_s1_valid    = ent_q[rob.rs1_rob_id].valid & ent_q[rob.rs1_rob_id].ready;
    assign rob.rob_s2_valid    = ent_q[rob.rs2_rob_id].valid & ent_q[rob.rs2_rob_id].ready;
    assign rob.commit          = commit;
    assign rob.commit_rd       = commit ? ent_q[head_q].rd : '0;
    assign rob.commit_rob_id   = commit ? head_q : '0;
    assign rob.commit_data     = commit ? WORD_SIZE'(ent_q[head_q].data) : '0;
    assign rob.commit_is_store = commit & ent_q[head_q].is_store;

    // Writebacks applied lowest priority first so that alu overrides mem overrides mul on a shared id.
    always_comb begin
        ent_d  = ent_q;
        head_d = commit ? nxt(head_q) : head_q;
        tail_d = alloc ? nxt(tail_q) : tail_q;
        cnt_d  = alloc & ~commit ? cnt_q + CNT_W'(1) : (~alloc & commit ? cnt_q - CNT_W'(1) : cnt_q);
        if (rob.mul_wb_bypass_enable && ent_q[rob.mul_wb_rob_id].valid) begin
            ent_d[rob.mul_wb_rob_id].ready = 1'b1;
            ent_d[rob.mul_wb_rob_id].data  = rob.mul_wb_data;
        end
        if (rob.mem_wb_bypass_enable && ent_q[rob.mem_wb_rob_id].valid) begin
            ent_d[rob.mem_wb_rob_id].ready = 1'b1;
            ent_d[rob.mem_wb_rob_id].data  = rob.mem_wb_data;
        end
        if (rob.alu_wb_bypass_enable && ent_q[rob.alu_wb_rob_id].valid) begin
            ent_d[rob.alu_wb_rob_id].ready = 1'b1;
            ent_d[rob.alu_wb_rob_id].data  = rob.alu_wb_data;
        end
        if (commit)
            ent_d[head_q].valid = 1'b0;
        if (alloc) begin
            ent_d[tail_q].valid    = 1'b1;
            ent_d[tail_q].ready    = 1'b0;
            ent_d[tail_q].is_store = rob.is_store;
            ent_d[tail_q].rd       = rob.rd;
        end
        if (rob.jump_taken) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                ent_d[i].valid = 1'b0;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                ent_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            ent_q  <= ent_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed checks of allocation, writeback, commit, flush and reset.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    reorder_buffer_if rif ();
    reorder_buffer dut (.clk(clk), .rst_n(rst_n), .rob(rif));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_off();
        rif.alu_wb_bypass_enable = 1'b0;
        rif.mem_wb_bypass_enable = 1'b0;
        rif.mul_wb_bypass_enable = 1'b0;
    endtask

    task automatic chk_commit(input string tag, input logic c, input logic [63:0] id,
                              input logic [63:0] rd, input logic [63:0] data, input logic st);
        chk({tag, ".commit"}, 64'(rif.commit), 64'(c));
        chk({tag, ".id"}, 64'(rif.commit_rob_id), id);
        chk({tag, ".rd"}, 64'(rif.commit_rd), rd);
        chk({tag, ".data"}, 64'(rif.commit_data), data);
        chk({tag, ".store"}, 64'(rif.commit_is_store), 64'(st));
    endtask

    initial begin
        rif.require_rob_entry = 1'b0;
        rif.is_store = 1'b0;
        rif.rd = '0;
        rif.rs1_rob_id = '0;
        rif.rs2_rob_id = '0;
        rif.alu_wb_rob_id = '0;
        rif.mem_wb_rob_id = '0;
        rif.mul_wb_rob_id = '0;
        rif.alu_wb_data = '0;
        rif.mem_wb_data = '0;
        rif.mul_wb_data = '0;
        rif.jump_taken = 1'b0;
        wb_off();
        #2;
        chk("rst.full", 64'(rif.full), 64'd0);
        chk("rst.tail", 64'(rif.assigned_rob_id), 64'd0);
        chk_commit("rst", 1'b0, 0, 0, 0, 1'b0);
        chk("rst.s1v", 64'(rif.rob_s1_valid), 64'd0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            rif.require_rob_entry = 1'b1;
            rif.rd = 5'(i + 1);
            rif.is_store = (i == 5);
            #1;
            chk("alloc.id", 64'(rif.assigned_rob_id), 64'(i));
            chk("alloc.full", 64'(rif.full), 64'd0);
            tick();
        end
        chk("full8", 64'(rif.full), 64'd1);
        tick();
        rif.require_rob_entry = 1'b0;
        rif.is_store = 1'b0;
        chk("full9", 64'(rif.full), 64'd1);
        chk("tail9", 64'(rif.assigned_rob_id), 64'd0);
        rif.rs1_rob_id = 3'd0;
        #1;
        chk("s1v.notready", 64'(rif.rob_s1_valid), 64'd0);

        rif.alu_wb_bypass_enable = 1'b1;
        rif.alu_wb_rob_id = 3'd2;
        rif.alu_wb_data = 32'hAA;
        tick();
        wb_off();
        rif.rs1_rob_id = 3'd2;
        rif.rs2_rob_id = 3'd0;
        #1;
        chk_commit("nohead", 1'b0, 0, 0, 0, 1'b0);
        chk("id2.s1v", 64'(rif.rob_s1_valid), 64'd1);
        chk("id2.s1d", 64'(rif.rob_s1_data), 64'hAA);
        chk("id0.s2v", 64'(rif.rob_s2_valid), 64'd0);

        rif.alu_wb_bypass_enable = 1'b1;
        rif.alu_wb_rob_id = 3'd0;
        rif.alu_wb_data = 32'h10;
        rif.mem_wb_bypass_enable = 1'b1;
        rif.mem_wb_rob_id = 3'd1;
        rif.mem_wb_data = 32'h20;
        tick();
        wb_off();
        rif.require_rob_entry = 1'b1;
        rif.rd = 5'd13;
        #1;
        chk_commit("c0", 1'b1, 0, 1, 64'h10, 1'b0);
        chk("c0.full", 64'(rif.full), 64'd1);
        chk("c0.tail", 64'(rif.assigned_rob_id), 64'd0);
        tick();
        chk_commit("c1", 1'b1, 1, 2, 64'h20, 1'b0);
        chk("c1.full", 64'(rif.full), 64'd0);
        chk("c1.tail", 64'(rif.assigned_rob_id), 64'd0);
        tick();
        rif.require_rob_entry = 1'b0;
        chk_commit("c2", 1'b1, 2, 3, 64'hAA, 1'b0);
        chk("c2.tail", 64'(rif.assigned_rob_id), 64'd1);
        tick();
        rif.rs1_rob_id = 3'd0;
        #1;
        chk_commit("c3idle", 1'b0, 0, 0, 0, 1'b0);
        chk("new0.s1v", 64'(rif.rob_s1_valid), 64'd0);

        rif.alu_wb_bypass_enable = 1'b1;
        rif.alu_wb_rob_id = 3'd3;
        rif.alu_wb_data = 32'h11;
        rif.mul_wb_bypass_enable = 1'b1;
        rif.mul_wb_rob_id = 3'd3;
        rif.mul_wb_data = 32'h22;
        rif.mem_wb_bypass_enable = 1'b1;
        rif.mem_wb_rob_id = 3'd1;
        rif.mem_wb_data = 32'h55;
        tick();
        wb_off();
        rif.rs1_rob_id = 3'd3;
        rif.rs2_rob_id = 3'd1;
        #1;
        chk("prio.s1d", 64'(rif.rob_s1_data), 64'h11);
        chk("prio.s1v", 64'(rif.rob_s1_valid), 64'd1);
        chk("drop.s2v", 64'(rif.rob_s2_valid), 64'd0);
        chk_commit("c3", 1'b1, 3, 4, 64'h11, 1'b0);
        tick();
        chk_commit("c4idle", 1'b0, 0, 0, 0, 1'b0);

        rif.alu_wb_bypass_enable = 1'b1;
        rif.alu_wb_rob_id = 3'd4;
        rif.alu_wb_data = 32'h44;
        rif.mem_wb_bypass_enable = 1'b1;
        rif.mem_wb_rob_id = 3'd5;
        rif.mem_wb_data = 32'h55;
        tick();
        wb_off();
        chk_commit("c4", 1'b1, 4, 5, 64'h44, 1'b0);
        rif.require_rob_entry = 1'b1;
        rif.rd = 5'd14;
        tick();
        chk_commit("c5", 1'b1, 5, 6, 64'h55, 1'b1);
        chk("c5.tail", 64'(rif.assigned_rob_id), 64'd2);
        rif.jump_taken = 1'b1;
        rif.alu_wb_bypass_enable = 1'b1;
        rif.alu_wb_rob_id = 3'd6;
        rif.alu_wb_data = 32'h66;
        #1;
        chk("flush.commit", 64'(rif.commit), 64'd1);
        tick();
        rif.jump_taken = 1'b0;
        rif.require_rob_entry = 1'b0;
        wb_off();
        rif.rs1_rob_id = 3'd6;
        rif.rs2_rob_id = 3'd0;
        #1;
        chk("flush.full", 64'(rif.full), 64'd0);
        chk("flush.tail", 64'(rif.assigned_rob_id), 64'd0);
        chk("flush.s1v", 64'(rif.rob_s1_valid), 64'd0);
        chk("flush.s2v", 64'(rif.rob_s2_valid), 64'd0);
        chk_commit("flush", 1'b0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            rif.require_rob_entry = 1'b1;
            rif.rd = 5'(20 + i);
            #1;
            chk("realloc.id", 64'(rif.assigned_rob_id), 64'(i));
            tick();
        end
        rif.require_rob_entry = 1'b0;
        rif.alu_wb_bypass_enable = 1'b1;
        rif.alu_wb_rob_id = 3'd0;
        rif.alu_wb_data = 32'h77;
        tick();
        wb_off();
        rif.rs1_rob_id = 3'd0;
        chk_commit("pre_rst", 1'b1, 0, 20, 64'h77, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_commit("mid_rst", 1'b0, 0, 0, 0, 1'b0);
        chk("mid_rst.tail", 64'(rif.assigned_rob_id), 64'd0);
        chk("mid_rst.full", 64'(rif.full), 64'd0);
        chk("mid_rst.s1v", 64'(rif.rob_s1_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        chk("held_rst.commit", 64'(rif.commit), 64'd0);
        tick();
        chk_commit("post_rst", 1'b0, 0, 0, 0, 1'b0);
        chk("post_rst.tail", 64'(rif.assigned_rob_id), 64'd0);
        tick();
        chk("post_rst2.commit", 64'(rif.commit), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter WORD_SIZE, default `WORD_SIZE (32): data width of every result field.
REQ-002 Parameter NUM_ENTRIES, default 2**`ROB_ENTRY_WIDTH (8): entry count; `ROB_ENTRY_WIDTH sets the ROB id width.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 require_rob_entry  in  1  decode requests allocation this cycle.
REQ-006 is_store  in  1  instruction being allocated is a store.
REQ-007 rd  in  `ARCH_REG_INDEX_SIZE  destination architectural register of the allocated instruction.
REQ-008 assigned_rob_id  out  `ROB_ENTRY_WIDTH  id granted to the current request (equals tail).
REQ-009 full  out  1  no free entry; allocation is refused.
REQ-010 rs1_rob_id, rs2_rob_id  in  `ROB_ENTRY_WIDTH each  operand lookup ids.
REQ-011 rob_s1_data, rob_s2_data  out  WORD_SIZE each  stored result of the looked-up entry.
REQ-012 rob_s1_valid, rob_s2_valid  out  1 each  looked-up entry is allocated and its result is written.
REQ-013 alu_/mem_/mul_wb_bypass_enable  in  1 each; alu_/mem_/mul_wb_rob_id  in  `ROB_ENTRY_WIDTH; alu_/mem_/mul_wb_data  in  WORD_SIZE: three writeback ports.
REQ-014 jump_taken  in  1  flush request.
REQ-015 commit  out  1  head entry retires this cycle.
REQ-016 commit_rd  out  `ARCH_REG_INDEX_SIZE; commit_rob_id  out  `ROB_ENTRY_WIDTH; commit_data  out  WORD_SIZE; commit_is_store  out  1: retiring entry fields.

Function
REQ-017 Storage SHALL be a circular buffer: per entry valid, ready, is_store, rd, data; head, tail, and count registers of width `ROB_ENTRY_WIDTH+1 for count.
REQ-018 An allocation SHALL occur at an edge when require_rob_entry=1 and full=0: entry[tail] gets valid=1, ready=0, rd, is_store; tail increments modulo NUM_ENTRIES.
REQ-019 assigned_rob_id SHALL be tail combinationally; full SHALL equal (count==NUM_ENTRIES), derived from registered state only.
REQ-020 When full=1, a request SHALL be ignored even if a commit happens in the same cycle; the freed slot becomes usable the next cycle.
REQ-021 A writeback SHALL set ready=1 and data on entry[wb_rob_id] at the edge, only if that entry is valid; writebacks to invalid entries are dropped.
REQ-022 Same-id writebacks in one cycle SHALL resolve with priority alu > mem > mul; distinct ids SHALL all be written.
REQ-023 Read ports SHALL be combinational from stored state; a same-cycle writeback is not forwarded (decode owns bypass).
REQ-024 commit SHALL equal entry[head].valid & entry[head].ready combinationally, with commit_* fields driven from entry[head]; the fields are 0 when commit=0.
REQ-025 On a commit edge, entry[head].valid SHALL clear and head SHALL increment modulo NUM_ENTRIES; at most one commit per cycle.
REQ-026 count SHALL be incremented by an allocation, decremented by a commit, and left unchanged when both occur in the same cycle.
REQ-027 With jump_taken=1, commit output SHALL still reflect head; at the edge all valid bits clear, head=tail=count=0, and same-cycle allocations and writebacks are discarded.
REQ-028 Pointer wrap from NUM_ENTRIES-1 to 0 SHALL be seamless for allocation, commit, and lookups.

Reset
REQ-029 While rst=0, the block SHALL asynchronously clear all valid and ready bits, head, tail, and count to 0.
REQ-030 Resulting output values SHALL be: full=0, assigned_rob_id=0, commit=0, all commit_* fields 0, rob_s*_valid=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight entries without producing a commit pulse.

Structure
REQ-032 `WORD_SIZE, `ROB_ENTRY_WIDTH, and `ARCH_REG_INDEX_SIZE SHALL come from the shared defines header; the rob_entry_t struct typedef SHALL live in the shared package.
REQ-033 The block SHALL be a single module with no sub-module; pointer logic and the entry array are inline.

Verification
REQ-034 Reset, then 8 allocations with rd=1..8 -> assigned_rob_id steps 0..7, and full=1 after the 8th; a 9th request is ignored and tail stays 0.
REQ-035 Write alu id2 data 0xAA while head=0 is not ready -> no commit; then write id0 and id1 -> commit pulses for ids 0, 1, 2 on consecutive cycles, with commit_data for id2 equal to 0xAA.
REQ-036 alu and mul both write id3 in one cycle (0x11, 0x22) -> rs1_rob_id=3 returns rob_s1_data=0x11 and rob_s1_valid=1.
REQ-037 Full buffer with head ready, plus require_rob_entry -> commit=1, no allocation that cycle; allocation succeeds the next cycle with assigned_rob_id=0 (wrap).
REQ-038 Five entries live, jump_taken=1 -> next cycle count=0, full=0, assigned_rob_id=0, and all rob_s*_valid=0.
REQ-039 rst driven low between clock edges with four entries live -> outputs zero immediately, and no commit pulse follows.
